// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg: shared types and helpers for the 4-entry bubble-sort controller.
//   - state_e        : controller states IDLE/CMP/SWAP/DONE
//   - ALU_SUB/ALU_NOP: opcodes driven on the shared ALU
//   - pair_idx()     : compare step -> lower index p of the pair (R[p], R[p+1])
//   - is_pass_end()  : compare step -> 1 when the step closes a bubble pass
// -----------------------------------------------------------------------------
package sort_pkg;

    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOP = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } state_e;

    // Three passes of shrinking length: pairs 0,1,2 then 0,1 then 0.
    function automatic logic [1:0] pair_idx(input logic [2:0] step);
        logic [1:0] p;
        case (step)
            3'd0:    p = 2'd0;
            3'd1:    p = 2'd1;
            3'd2:    p = 2'd2;
            3'd3:    p = 2'd0;
            3'd4:    p = 2'd1;
            3'd5:    p = 2'd0;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    function automatic logic is_pass_end(input logic [2:0] step);
        return (step == 3'd2) || (step == 3'd4) || (step == 3'd5);
    endfunction

endpackage

// File: rtl/sort_cas_mux.sv
// -----------------------------------------------------------------------------
// sort_cas_mux: compare-and-swap operand path for the 4-entry sorter.
// Selects the pair (R[p], R[p+1]) for the ALU and presents the register file
// with that pair exchanged, ready to be written back on a SWAP.
// Ports:
//   r0_i..r3_i  in  N  current register contents
//   p_i         in  2  lower pair index (0..2)
//   a_o, b_o    out N  R[p], R[p+1]
//   w0_o..w3_o  out N  register contents with R[p] and R[p+1] exchanged
// -----------------------------------------------------------------------------
module sort_cas_mux #(
    parameter int N = 4
) (
    input  logic [N-1:0] r0_i,
    input  logic [N-1:0] r1_i,
    input  logic [N-1:0] r2_i,
    input  logic [N-1:0] r3_i,
    input  logic [1:0]   p_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [N-1:0] w0_o,
    output logic [N-1:0] w1_o,
    output logic [N-1:0] w2_o,
    output logic [N-1:0] w3_o
);

    // Operand select and exchanged write-back image for the selected pair.
    always_comb begin
        a_o  = r0_i;
        b_o  = r1_i;
        w0_o = r0_i;
        w1_o = r1_i;
        w2_o = r2_i;
        w3_o = r3_i;
        case (p_i)
            2'd0: begin
                a_o  = r0_i;
                b_o  = r1_i;
                w0_o = r1_i;
                w1_o = r0_i;
            end
            2'd1: begin
                a_o  = r1_i;
                b_o  = r2_i;
                w1_o = r2_i;
                w2_o = r1_i;
            end
            2'd2: begin
                a_o  = r2_i;
                b_o  = r3_i;
                w2_o = r3_i;
                w3_o = r2_i;
            end
            default: begin
                a_o = r0_i;
                b_o = r1_i;
            end
        endcase
    end

endmodule

// File: rtl/sort_ctrl.sv
// -----------------------------------------------------------------------------
// sort_ctrl: sequencing controller for a 4-entry, 3-pass bubble sort that does
// its compares on a shared external ALU (SUB request, borrow/zero flags back).
// Optional build macro SORT_EARLY_EXIT_EN: finish at a pass boundary when the
// pass just completed made no swap.
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-low reset
//   start          in   begin sort (accepted in IDLE or DONE only)
//   x0..x3         in   N-bit unsigned operands, captured on the start edge
//   s0..s3         out  sorted result, s0 smallest, registered
//   done           out  level, high from completion until next start/reset
//   busy           out  high in CMP or SWAP
//   alu_a, alu_b   out  R[p], R[p+1] while busy, else 0
//   alu_op         out  ALU_SUB while busy, else 3'b000
//   alu_cf, alu_zf in   ALU borrow (a<b) and zero (a==b) flags
// -----------------------------------------------------------------------------
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int         N       = 4,
    parameter logic [2:0] ALU_SUB = sort_pkg::ALU_SUB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x0,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] x3,
    output logic [N-1:0] s0,
    output logic [N-1:0] s1,
    output logic [N-1:0] s2,
    output logic [N-1:0] s3,
    output logic         done,
    output logic         busy,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic         alu_cf,
    input  logic         alu_zf
);

    state_e               state_q, state_d;
    logic [3:0][N-1:0]    r_q, r_d;
    logic [3:0][N-1:0]    s_q, s_d;
    logic [2:0]           step_q, step_d;
    logic                 pass_swapped_q, pass_swapped_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [N-1:0]         mux_a_s, mux_b_s;
    logic [N-1:0]         w0_s, w1_s, w2_s, w3_s;
    logic                 swap_req_s;
    logic                 pass_end_s;

    sort_cas_mux #(.N(N)) u_cas_mux (
        .r0_i (r_q[0]),
        .r1_i (r_q[1]),
        .r2_i (r_q[2]),
        .r3_i (r_q[3]),
        .p_i  (pair_idx(step_q)),
        .a_o  (mux_a_s),
        .b_o  (mux_b_s),
        .w0_o (w0_s),
        .w1_o (w1_s),
        .w2_o (w2_s),
        .w3_o (w3_s)
    );

    // Strictly greater only: equal operands stay in place, keeping the sort stable.
    assign swap_req_s = !alu_cf && !alu_zf;
    assign pass_end_s = is_pass_end(step_q);

    // Next-state, datapath update and result capture.
    always_comb begin
        state_d        = state_q;
        r_d            = r_q;
        s_d            = s_q;
        step_d         = step_q;
        pass_swapped_d = pass_swapped_q;
        done_d         = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    r_d            = {x3, x2, x1, x0};
                    step_d         = 3'd0;
                    pass_swapped_d = 1'b0;
                    done_d         = 1'b0;
                    state_d        = CMP;
                end else begin
                    state_d = state_q;
                end
            end
            CMP: begin
                if (swap_req_s) begin
                    state_d = SWAP;
                end else if (step_q == 3'd5) begin
                    state_d = DONE;
`ifdef SORT_EARLY_EXIT_EN
                end else if (pass_end_s && !pass_swapped_q) begin
                    state_d = DONE;
`endif
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = CMP;
                    if (pass_end_s) begin
                        pass_swapped_d = 1'b0;
                    end else begin
                        pass_swapped_d = pass_swapped_q;
                    end
                end
            end
            SWAP: begin
                r_d            = {w3_s, w2_s, w1_s, w0_s};
                pass_swapped_d = 1'b1;
                if (step_q == 3'd5) begin
                    state_d = DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = CMP;
                    // Crossing into the next pass starts a fresh swap record.
                    if (pass_end_s) begin
                        pass_swapped_d = 1'b0;
                    end else begin
                        pass_swapped_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result and done are published on the same edge that enters DONE,
        // using the post-swap register image when the last step was a SWAP.
        if ((state_d == DONE) && (state_q != DONE)) begin
            s_d    = r_d;
            done_d = 1'b1;
        end else begin
            s_d = s_d;
        end

        busy_d = (state_d == CMP) || (state_d == SWAP);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            r_q            <= '0;
            s_q            <= '0;
            step_q         <= 3'd0;
            pass_swapped_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            r_q            <= r_d;
            s_q            <= s_d;
            step_q         <= step_d;
            pass_swapped_q <= pass_swapped_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    assign s0     = s_q[0];
    assign s1     = s_q[1];
    assign s2     = s_q[2];
    assign s3     = s_q[3];
    assign done   = done_q;
    assign busy   = busy_q;
    // The ALU is shared: drive it only while this controller owns it.
    assign alu_a  = busy_q ? mux_a_s : {N{1'b0}};
    assign alu_b  = busy_q ? mux_b_s : {N{1'b0}};
    assign alu_op = busy_q ? ALU_SUB : ALU_NOP;

endmodule

// File: tb/tb_sort_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sort_ctrl: self-checking bench for sort_ctrl with a behavioural ALU and a
// reference bubble-sort model that predicts results and completion latency.
// -----------------------------------------------------------------------------
module tb_sort_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] x0, x1, x2, x3;
    logic [N-1:0] s0, s1, s2, s3;
    logic         done, busy;
    logic [N-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic         alu_cf, alu_zf;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] prev_s [4];

    always #5 clk = ~clk;

    // Behavioural shared ALU flags.
    assign alu_cf = (alu_a < alu_b);
    assign alu_zf = (alu_a == alu_b);

    sort_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .done(done), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_cf(alu_cf), .alu_zf(alu_zf)
    );

    // Reference: three bubble passes; each compare costs one cycle, each swap one more.
    task automatic model_sort(input logic [N-1:0] a, b, c, d,
                              output logic [N-1:0] o [4], output int lat);
        logic [N-1:0] r [4];
        logic [N-1:0] t;
        bit sw;
        bit stop;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        lat = 0;
        stop = 1'b0;
        for (int pass = 0; pass < 3; pass++) begin
            if (!stop) begin
                sw = 1'b0;
                for (int j = 0; j < 3 - pass; j++) begin
                    lat++;
                    if (r[j] > r[j+1]) begin
                        t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                        lat++;
                        sw = 1'b1;
                    end
                end
`ifdef SORT_EARLY_EXIT_EN
                if (!sw) stop = 1'b1;
`endif
            end
        end
        o = r;
    endtask

    task automatic run_sort(input logic [N-1:0] a, b, c, d, input bit inject, input string tag);
        logic [N-1:0] exp_s [4];
        int exp_lat;
        int lat;
        bit got;
        model_sort(a, b, c, d, exp_s, exp_lat);
        @(negedge clk);
        x0 = a; x1 = b; x2 = c; x3 = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || alu_op !== 3'b001 || alu_a !== a || alu_b !== b) begin
            n_fail++;
            $display("FAIL %s first_cmp: busy=%0b done=%0b op=%0d a=%0d b=%0d, expected busy=1 done=0 op=1 a=%0d b=%0d",
                     tag, busy, done, alu_op, alu_a, alu_b, a, b);
        end
        n_checks++;
        if (s0 !== prev_s[0] || s1 !== prev_s[1] || s2 !== prev_s[2] || s3 !== prev_s[3]) begin
            n_fail++;
            $display("FAIL %s s_hold: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d",
                     tag, s0, s1, s2, s3, prev_s[0], prev_s[1], prev_s[2], prev_s[3]);
        end
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (inject && lat == 2) begin
                    start = 1'b1; x0 = '0; x1 = '0; x2 = '0; x3 = '0;
                end else begin
                    start = 1'b0;
                end
                n_checks++;
                if (busy !== 1'b1 || alu_op !== 3'b001) begin
                    n_fail++;
                    $display("FAIL %s busy_during: busy=%0b op=%0d at cycle %0d, expected busy=1 op=1",
                             tag, busy, alu_op, lat);
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (!got || lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d (done seen=%0b) expected %0d", tag, lat, got, exp_lat);
        end
        n_checks++;
        if (s0 !== exp_s[0] || s1 !== exp_s[1] || s2 !== exp_s[2] || s3 !== exp_s[3]) begin
            n_fail++;
            $display("FAIL %s result: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d",
                     tag, s0, s1, s2, s3, exp_s[0], exp_s[1], exp_s[2], exp_s[3]);
        end
        n_checks++;
        if (busy !== 1'b0 || alu_op !== 3'b000 || alu_a !== 4'd0 || alu_b !== 4'd0) begin
            n_fail++;
            $display("FAIL %s alu_released: busy=%0b op=%0d a=%0d b=%0d expected all 0",
                     tag, busy, alu_op, alu_a, alu_b);
        end
        prev_s = exp_s;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1;
        x0 = 4'd9; x1 = 4'd3; x2 = 4'd12; x3 = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({s0, s1, s2, s3} !== 16'd0 || done !== 1'b0 || busy !== 1'b0 ||
            alu_op !== 3'b000 || alu_a !== 4'd0 || alu_b !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: s=%0d,%0d,%0d,%0d done=%0b busy=%0b op=%0d expected all 0",
                     s0, s1, s2, s3, done, busy, alu_op);
        end
        start = 1'b0; rst = 1'b1;
        for (int i = 0; i < 4; i++) prev_s[i] = '0;
    endtask

    task automatic test_plan_vectors();
        run_sort(4'd3, 4'd7, 4'd6, 4'd1, 1'b0, "plan_3761");
        run_sort(4'd10, 4'd8, 4'd15, 4'd4, 1'b1, "busy_start_ignored");
        run_sort(4'd5, 4'd5, 4'd2, 4'd5, 1'b0, "equal_stable");
        run_sort(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, "presorted");
        run_sort(4'd15, 4'd10, 4'd8, 4'd4, 1'b0, "reversed");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        x0 = 4'd12; x1 = 4'd11; x2 = 4'd6; x3 = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({s0, s1, s2, s3} !== 16'd0 || done !== 1'b0 || busy !== 1'b0 ||
            alu_op !== 3'b000 || alu_a !== 4'd0 || alu_b !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset: s=%0d,%0d,%0d,%0d done=%0b busy=%0b op=%0d expected all 0",
                     s0, s1, s2, s3, done, busy, alu_op);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) prev_s[i] = '0;
        run_sort(4'd2, 4'd9, 4'd4, 4'd6, 1'b0, "after_mid_reset");
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, c, d;
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            run_sort(a, b, c, d, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        x0 = '0; x1 = '0; x2 = '0; x3 = '0;
        test_reset();
        test_plan_vectors();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
Sequencing controller for the 4-entry sort datapath. It latches four N-bit operands and runs a 3-pass bubble sort. Each compare is done on the shared lab ALU, which it drives through a SUB request and whose borrow/zero flags it reads. Ascending results go to s0..s3 with a level done flag. The ALU stays shared: the controller drives ALU inputs only while busy.

Parameters:
N, 4, operand width in bits
ALU_SUB, 3'b001, ALU opcode driven on alu_op for compare

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
start  in  1  begin sort; sampled only in IDLE or DONE
x0..x3  in  N each  unsigned operands, sampled on the start edge
s0..s3  out  N each  sorted result, s0 smallest; registered
done  out  1  level; high from sort completion until next accepted start or reset
busy  out  1  high while in CMP or SWAP
alu_a, alu_b  out  N each  ALU operands (R[p], R[p+1]); 0 when not busy
alu_op  out  3  ALU_SUB when busy, else 3'b000
alu_cf  in  1  combinational borrow from ALU: 1 iff alu_a < alu_b (unsigned)
alu_zf  in  1  combinational zero flag: 1 iff alu_a == alu_b

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, R0..R3=0, s0..s3=0, step=0, done=0, busy=0. Reset dominates start and applies mid-sort, discarding in-flight work.
- Internal regs R0..R3 (N bits), step (3 bits, 0..5), pass_swapped (1 bit).
- Pair table: step 0,1,2,3,4,5 selects p = 0,1,2,0,1,0. Pass boundaries fall after step 2 (pass 1), step 4 (pass 2) and step 5 (pass 3).
- IDLE/DONE: on start=1, R<=x0..x3, step<=0, pass_swapped<=0, done<=0, next=CMP. s holds its old values.
- CMP: drive alu_a=R[p], alu_b=R[p+1], alu_op=ALU_SUB.
  - swap_req = !alu_cf && !alu_zf, i.e. R[p] > R[p+1]. Equal operands are never swapped (stable).
  - If swap_req: next=SWAP.
  - Else, if step==5: next=DONE.
  - Else: step<=step+1, next=CMP.
- SWAP: R[p]<=R[p+1] and R[p+1]<=R[p]; pass_swapped<=1. Then next=DONE if step==5, else step<=step+1 and next=CMP. ALU outputs stay driven in SWAP and are ignored.
- pass_swapped clears whenever step crosses a pass boundary.
- Entering DONE: s0..s3<=R0..R3 and done<=1 on the same edge.
- Latency: done is visible 6 + S clock edges after the start edge, where S is the swap count (0..6).
- start while busy is ignored. start in DONE restarts the sort: done drops on the next edge and s holds until the new completion.
- No arithmetic beyond the ALU compare. Widths are fixed at N, so there is no overflow path.

Optional Feature:
Macro SORT_EARLY_EXIT_EN.
- Defined: at a pass boundary (leaving step 2 or step 4), if pass_swapped==0 after that step's compare, go directly to DONE. Fully sorted input finishes in 3 edges.
- Undefined: all 6 compares always run, giving fixed latency 6+S. pass_swapped is still maintained but has no effect.

Decomposition:
- Package sort_pkg holds:
  - state enum IDLE/CMP/SWAP/DONE
  - ALU opcode constants (ALU_SUB, ALU_NOP)
  - pair-index function: step -> p
  - pass-end function: step -> bool
- One natural sub-module, sort_cas_mux: an N-bit 4:2 operand select plus swap write-back, instantiated once by sort_ctrl.
- The FSM stays in sort_ctrl.

Test Plan:
- Reset, then start with x=3,7,6,1 -> busy for 10 cycles, 4 swaps, s=1,3,6,7, done=1 at edge 10.
- start with x=10,8,15,4 -> s=4,8,10,15, done after 10 edges. While busy, pulse start with x=0,0,0,0 -> ignored, same result.
- x=5,5,2,5 -> s=2,5,5,5. Equal pairs never swap: 2 swaps, done at edge 8.
- x=1,2,3,4 -> s=1,2,3,4. Done at edge 3 with SORT_EARLY_EXIT_EN defined, edge 6 without. x=15,10,8,4 -> 6 swaps, done at edge 12.
- Mid-sort rst=0 at edge 4 -> next cycle s=0, done=0, busy=0, alu_op=0. Then start with x=2,9,4,6 -> s=2,4,6,9.
- Check ALU sharing: alu_op=ALU_SUB and alu_a/alu_b match R[p],R[p+1] only while busy; alu_a=alu_b=0 and alu_op=0 in IDLE and DONE.
